// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port ram between instruction fetch and data load/store,
// holding the granted request stable until ram reports ACCESS.
module memory_arbiter #(
    parameter int          DBURST  = 4,
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] BAD     = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);
    localparam int CW = $clog2(DBURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_timer;
    logic          r_err;
    logic          w_dreq, w_grant, w_drop, w_done, w_abort;

    always_comb begin
        w_dreq  = dREN | dWEN;
        w_grant = r_state != IDLE;
        w_drop  = (r_state == DGRANT && !w_dreq) || (r_state == IGRANT && !iREN);
        w_done  = w_grant && !w_drop && ramstate == 2'd2;
        w_abort = w_grant && !w_drop && ramstate != 2'd2 &&
                  (ramstate == 2'd3 || r_timer == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = (w_dreq && (!iREN || r_cnt < CW'(DBURST))) ? DGRANT : iREN ? IGRANT : IDLE;
        else if (w_drop || w_done || w_abort)
            w_next = IDLE;
    end

    // Timer restarts in IDLE so every grant gets a fresh TIMEOUT window.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt   <= '0;
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_timer <= w_grant ? r_timer + TW'(1) : '0;
            r_err   <= r_err | w_abort;
            if (w_done)
                r_cnt <= (r_state == DGRANT && iREN) ?
                         ((r_cnt == CW'(DBURST)) ? r_cnt : r_cnt + CW'(1)) : '0;
        end
    end

    always_comb begin
        iwait    = !(w_done && r_state == IGRANT);
        dwait    = !(w_done && r_state == DGRANT);
        iload    = iwait ? BAD : ramload;
        dload    = dwait ? BAD : ramload;
        ramaddr  = (r_state == DGRANT) ? daddr : (r_state == IGRANT) ? iaddr : 32'd0;
        ramstore = (r_state == DGRANT) ? dstore : 32'd0;
        ramWEN   = r_state == DGRANT && dWEN;
        ramREN   = r_state == IGRANT || (r_state == DGRANT && dREN && !dWEN);
        err      = r_err;
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized checks of memory_arbiter against a
// behavioural ram with configurable latency and a shadow memory.
module tb_memory_arbiter;
    localparam int DBURST  = 4;
    localparam int TIMEOUT = 64;
    localparam logic [31:0] BAD = 32'hBAD1BAD1;

    logic        CLK = 0, RST = 1;
    logic        iREN = 0, dREN = 0, dWEN = 0;
    logic [31:0] iaddr = 0, daddr = 0, dstore = 0;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    memory_arbiter #(.DBURST(DBURST), .TIMEOUT(TIMEOUT), .BAD(BAD)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    // Ram model: ACCESS once the same request has been held for lat_cfg cycles.
    logic [31:0] mem [0:255];
    logic [31:0] sh  [0:255];
    int          lat_cfg = 5, rc = 0, run;
    logic        p_act = 0, p_ren = 0, p_wen = 0, force_busy = 0, force_err = 0;
    logic [31:0] p_addr = 0;
    logic        act, same;

    always_comb begin
        act      = ramREN | ramWEN;
        same     = p_act && p_addr == ramaddr && p_ren == ramREN && p_wen == ramWEN;
        run      = act ? (same ? rc : 0) + 1 : 0;
        ramstate = !act ? 2'd0 : (force_err || (ramREN && ramWEN)) ? 2'd3 :
                   (!force_busy && run >= lat_cfg) ? 2'd2 : 2'd1;
        ramload  = mem[ramaddr[9:2]];
    end

    always @(posedge CLK) begin
        if (ramWEN && ramstate == 2'd2) mem[ramaddr[9:2]] <= ramstore;
        rc     <= run;
        p_act  <= act;
        p_ren  <= ramREN;
        p_wen  <= ramWEN;
        p_addr <= ramaddr;
    end

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1; iREN = 0; dREN = 0; dWEN = 0;
        @(posedge CLK); #1;
        RST = 0;
    endtask

    task automatic wait_pulse(input bit is_i, output int lat, output bit ok, output logic [31:0] data);
        lat = 0; ok = 0; data = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            lat++;
            if (is_i ? !iwait : !dwait) begin
                ok = 1;
                data = is_i ? iload : dload;
                return;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic xfer(input bit is_i, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] data, output int lat);
        bit ok;
        @(posedge CLK); #1;
        if (is_i) begin iREN = 1; iaddr = a; end
        else begin dREN = rd; dWEN = wr; daddr = a; dstore = d; end
        wait_pulse(is_i, lat, ok, data);
        chk("xfer_done", 32'(ok), 1);
        @(posedge CLK); #1;
        if (is_i) iREN = 0; else begin dREN = 0; dWEN = 0; end
        @(negedge CLK);
        chk("one_pulse", 32'(is_i ? iwait : dwait), 1);
    endtask

    logic [31:0] got, v;
    int          lat, n, pulse, npulse;
    bit          ok;
    bit          ord [0:9];

    initial begin
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            mem[i] <= v;
            sh[i] = v;
        end
        #1;
        chk("rst_iwait", 32'(iwait), 1);
        chk("rst_dwait", 32'(dwait), 1);
        chk("rst_ren", 32'({ramREN, ramWEN}), 0);
        chk("rst_addr", ramaddr, 0);
        chk("rst_store", ramstore, 0);
        chk("rst_iload", iload, BAD);
        chk("rst_dload", dload, BAD);
        chk("rst_err", 32'(err), 0);
        @(posedge CLK); #1;
        RST = 0;

        // Instruction read: one IDLE cycle plus ram latency.
        xfer(1, 0, 0, 32'h40, 0, got, lat);
        chk("i_lat", lat, 1 + lat_cfg);
        chk("i_data", got, sh[32'h40 >> 2]);

        // Data write then read back.
        xfer(0, 0, 1, 32'h100, 32'hCAFEF00D, got, lat);
        sh[32'h100 >> 2] = 32'hCAFEF00D;
        xfer(0, 1, 0, 32'h100, 0, got, lat);
        chk("d_readback", got, 32'hCAFEF00D);

        // Both requesters held: data wins DBURST times, then instr.
        lat_cfg = 2;
        do_reset();
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h20;
        npulse = 0;
        for (int c = 0; c < 500 && npulse < 10; c++) begin
            @(negedge CLK);
            chk("excl", 32'(!iwait && !dwait), 0);
            if (!dwait) ord[npulse++] = 1;
            else if (!iwait) ord[npulse++] = 0;
            @(posedge CLK); #1;
        end
        iREN = 0; dREN = 0;
        chk("ord_count", npulse, 10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("ord%0d", k), 32'(ord[k]), 32'((k % (DBURST + 1)) != DBURST));

        // Timeout: ram stuck BUSY for the whole grant.
        do_reset();
        force_busy = 1;
        dREN = 1; daddr = 32'h180;
        n = 0; pulse = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (!dwait) pulse = 1;
            if (ramREN) n++;
            else if (n > 0) break;
            @(posedge CLK); #1;
        end
        chk("to_cycles", n, TIMEOUT);
        chk("to_pulse", pulse, 0);
        chk("to_err", 32'(err), 1);
        @(posedge CLK); #1;
        force_busy = 0;
        wait_pulse(0, lat, ok, got);
        chk("to_retry", 32'(ok), 1);
        chk("to_retry_data", got, sh[32'h180 >> 2]);
        @(posedge CLK); #1;
        dREN = 0;

        // Async reset mid-grant clears everything at once.
        dREN = 1; daddr = 32'h1C0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("pre_rst_grant", 32'(ramREN), 1);
        RST = 1;
        #1;
        chk("arst_waits", 32'({iwait, dwait}), 3);
        chk("arst_ren", 32'({ramREN, ramWEN}), 0);
        chk("arst_err", 32'(err), 0);
        @(posedge CLK); #1;
        RST = 0; dREN = 0;
        @(negedge CLK);
        chk("arst_idle", ramaddr, 0);

        // dREN and dWEN together become a pure write.
        lat_cfg = 3;
        v = $urandom;
        dREN = 1; dWEN = 1; daddr = 32'h80; dstore = v;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rw_wen", 32'(ramWEN), 1);
        chk("rw_ren", 32'(ramREN), 0);
        @(posedge CLK); #1;
        wait_pulse(0, lat, ok, got);
        chk("rw_done", 32'(ok), 1);
        chk("rw_err", 32'(err), 0);
        @(posedge CLK); #1;
        dREN = 0; dWEN = 0;
        sh[32'h80 >> 2] = v;
        xfer(0, 1, 0, 32'h80, 0, got, lat);
        chk("rw_readback", got, v);

        // Request dropped mid-grant: silent abort.
        dREN = 1; daddr = 32'h90;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("drop_grant", 32'(ramREN), 1);
        @(posedge CLK); #1;
        dREN = 0;
        @(negedge CLK);
        chk("drop_dwait", 32'(dwait), 1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("drop_idle", 32'(ramREN), 0);
        chk("drop_err", 32'(err), 0);

        // ram ERROR during a grant aborts and sets err.
        force_err = 1;
        @(posedge CLK); #1;
        dREN = 1; daddr = 32'hA0;
        n = 0;
        for (int c = 0; c < 20 && !ramREN; c++) @(negedge CLK);
        chk("e_grant", 32'(ramREN), 1);
        chk("e_dwait", 32'(dwait), 1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("e_idle", 32'(ramREN), 0);
        chk("e_err", 32'(err), 1);
        @(posedge CLK); #1;
        force_err = 0;
        wait_pulse(0, lat, ok, got);
        chk("e_retry", got, sh[32'hA0 >> 2]);
        @(posedge CLK); #1;
        dREN = 0;

        // Randomized concurrent traffic against the shadow memory.
        do_reset();
        begin
            bit i_act = 0, d_act = 0;
            int i_since = 0, i_age = 0, d_age = 0, max_age = 0;
            for (int c = 0; c < 3000; c++) begin
                @(posedge CLK); #1;
                iREN = i_act;
                if (!d_act) begin dREN = 0; dWEN = 0; end
                if (c % 500 == 0) lat_cfg = $urandom_range(6, 1);
                if (!i_act && $urandom_range(3) == 0) begin
                    i_act = 1; iREN = 1; i_since = 0; i_age = 0;
                    iaddr = {22'b0, 8'($urandom), 2'b0};
                end
                if (!d_act && $urandom_range(2) == 0) begin
                    d_act = 1; d_age = 0;
                    dWEN = 1'($urandom_range(1));
                    dREN = !dWEN || $urandom_range(3) == 0;
                    daddr = {22'b0, 8'($urandom), 2'b0};
                    dstore = $urandom;
                end
                @(negedge CLK);
                chk("r_excl", 32'(!iwait && !dwait), 0);
                if (i_act) i_age++;
                if (d_act) d_age++;
                max_age = (i_age > max_age) ? i_age : max_age;
                max_age = (d_age > max_age) ? d_age : max_age;
                if (!iwait) begin
                    chk("r_ireq", 32'(i_act), 1);
                    chk("r_iload", iload, sh[iaddr[9:2]]);
                    i_act = 0;
                end
                if (!dwait) begin
                    chk("r_dreq", 32'(d_act), 1);
                    if (dWEN) sh[daddr[9:2]] = dstore;
                    else chk("r_dload", dload, sh[daddr[9:2]]);
                    if (iREN) begin
                        i_since++;
                        chk("r_burst", 32'(i_since <= DBURST), 1);
                    end
                    d_act = 0;
                end
            end
            chk("r_stall", 32'(max_age < 200), 1);
            chk("r_err", 32'(err), 0);
        end
        @(posedge CLK); #1;
        iREN = 0; dREN = 0; dWEN = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
